// File: rtl/acs_stage.sv
// Add-compare-select stage for the rate-1/2, K=3 (7,5) Viterbi decoder, 4 states, frame based.
// Define ACS_NORM_EN for MSB-clear metric normalisation; otherwise each new metric saturates.
module acs_stage #(
    parameter int unsigned PM_W      = 6,
    parameter int unsigned INIT_BIAS = 8,
    parameter int unsigned FRAME_LEN = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [1:0]        data_recv,
    output logic              out_valid,
    output logic [3:0]        decision,
    output logic [1:0]        best_state,
    output logic              frame_end,
    output logic [4*PM_W-1:0] pm_flat
);

    localparam int unsigned     CW    = PM_W + 1;
    localparam int unsigned     CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);
    localparam logic [PM_W-1:0] BIAS  = PM_W'(INIT_BIAS);
`ifndef ACS_NORM_EN
    localparam logic [CW-1:0]   PM_MAX = {1'b0, {PM_W{1'b1}}};
`endif

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [PM_W-1:0]  pm      [4];
    logic [PM_W-1:0]  pm_new  [4];
    logic [CW-1:0]    cand0   [4];
    logic [CW-1:0]    cand1   [4];
    logic [3:0]       dec_new;
    logic [1:0]       best_new;
    logic [PM_W-1:0]  best_pm;

    assign pm_flat = {pm[3], pm[2], pm[1], pm[0]};

    // Hamming distance between the branch code word {c0,c1} and the received symbol
    function automatic logic [1:0] branch_metric(input logic [1:0] pred, input logic u,
                                                 input logic [1:0] sym);
        logic c0;
        logic c1;
        c0 = u ^ pred[1] ^ pred[0];
        c1 = u ^ pred[0];
        return {1'b0, c0 ^ sym[1]} + {1'b0, c1 ^ sym[0]};
    endfunction

    always_comb begin
        cand0    = '{default: '0};
        cand1    = '{default: '0};
        pm_new   = '{default: '0};
        dec_new  = '0;
        best_new = '0;
        best_pm  = '0;
        for (int n = 0; n < 4; n++) begin
            logic [1:0] ns;
            logic [1:0] p0;
            logic [1:0] p1;
            ns = 2'(n);
            p0 = {ns[0], 1'b0};
            p1 = {ns[0], 1'b1};
            cand0[n] = {1'b0, pm[p0]} + CW'(branch_metric(p0, ns[1], data_recv));
            cand1[n] = {1'b0, pm[p1]} + CW'(branch_metric(p1, ns[1], data_recv));
`ifndef ACS_NORM_EN
            if (cand0[n] > PM_MAX) cand0[n] = PM_MAX;
            if (cand1[n] > PM_MAX) cand1[n] = PM_MAX;
`endif
            dec_new[n] = (cand1[n] < cand0[n]);
            pm_new[n]  = dec_new[n] ? PM_W'(cand1[n]) : PM_W'(cand0[n]);
        end
`ifdef ACS_NORM_EN
        // All metrics in the upper half: shift the whole set down by 2^(PM_W-1)
        if (pm_new[0][PM_W-1] && pm_new[1][PM_W-1] && pm_new[2][PM_W-1] && pm_new[3][PM_W-1]) begin
            for (int n = 0; n < 4; n++) pm_new[n][PM_W-1] = 1'b0;
        end
`endif
        best_pm = pm_new[0];
        for (int n = 1; n < 4; n++) begin
            if (pm_new[n] < best_pm) begin
                best_pm  = pm_new[n];
                best_new = 2'(n);
            end
        end
    end

    // Frame FSM, metric registers and registered decision outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            count      <= '0;
            pm[0]      <= '0;
            pm[1]      <= BIAS;
            pm[2]      <= BIAS;
            pm[3]      <= BIAS;
            out_valid  <= 1'b0;
            decision   <= '0;
            best_state <= '0;
            frame_end  <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            frame_end <= 1'b0;
            if (start) begin
                state <= RUN;
                count <= '0;
                pm[0] <= '0;
                pm[1] <= BIAS;
                pm[2] <= BIAS;
                pm[3] <= BIAS;
            end else if (state == RUN && in_valid) begin
                for (int n = 0; n < 4; n++) pm[n] <= pm_new[n];
                decision   <= dec_new;
                best_state <= best_new;
                out_valid  <= 1'b1;
                if (count == LAST) begin
                    frame_end <= 1'b1;
                    count     <= '0;
                    state     <= IDLE;
                end else begin
                    count <= count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_acs_stage.sv
// Scoreboard bench for acs_stage: two instances (normal bias and a high bias that exercises clamping)
// share stimulus; a forward-trellis model predicts each output, a negedge monitor pops and compares.
module tb_acs_stage;

    localparam int PM_W      = 5;
    localparam int FRAME_LEN = 64;
    localparam int PM_MAX    = 31;
    localparam int HALF      = 16;
    localparam int BIAS_A    = 8;
`ifdef ACS_NORM_EN
    localparam bit NORM   = 1'b1;
    localparam int BIAS_B = 8;
`else
    localparam bit NORM   = 1'b0;
    localparam int BIAS_B = 31;
`endif

    typedef struct {
        logic [3:0]        dec;
        logic [1:0]        best;
        logic              fe;
        logic [4*PM_W-1:0] pm;
    } exp_t;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0;
    logic [1:0] data_recv = 2'b00;
    logic out_valid_a, frame_end_a, out_valid_b, frame_end_b;
    logic [3:0] decision_a, decision_b;
    logic [1:0] best_state_a, best_state_b;
    logic [4*PM_W-1:0] pm_flat_a, pm_flat_b;

    acs_stage #(.PM_W(PM_W), .INIT_BIAS(BIAS_A), .FRAME_LEN(FRAME_LEN)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .data_recv(data_recv),
        .out_valid(out_valid_a), .decision(decision_a), .best_state(best_state_a),
        .frame_end(frame_end_a), .pm_flat(pm_flat_a));

    acs_stage #(.PM_W(PM_W), .INIT_BIAS(BIAS_B), .FRAME_LEN(FRAME_LEN)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .data_recv(data_recv),
        .out_valid(out_valid_b), .decision(decision_b), .best_state(best_state_b),
        .frame_end(frame_end_b), .pm_flat(pm_flat_b));

    always #5 clk = ~clk;

    exp_t q_a[$];
    exp_t q_b[$];
    int   checks = 0, errors = 0;
    int   pm_m[2][4];
    int   pw[4];
    bit   running = 1'b0;
    int   sym_cnt = 0;
    int   obs_idx = 0;
    logic [3:0] dec_log[FRAME_LEN];
    bit   bits[FRAME_LEN];

    function automatic logic [4*PM_W-1:0] pk(input int a0, input int a1, input int a2, input int a3);
        return {PM_W'(a3), PM_W'(a2), PM_W'(a1), PM_W'(a0)};
    endfunction

    function automatic int fld(input logic [4*PM_W-1:0] v, input int i);
        return int'(v[i*PM_W +: PM_W]);
    endfunction

    function automatic logic [1:0] enc(input bit u, input logic [1:0] s);
        return {u ^ s[1] ^ s[0], u ^ s[0]};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic model_init();
        for (int i = 0; i < 4; i++) begin
            pm_m[0][i] = (i == 0) ? 0 : BIAS_A;
            pm_m[1][i] = (i == 0) ? 0 : BIAS_B;
            pw[i]      = pm_m[0][i];
        end
    endtask

    // Walk every (state, input bit) transition forward; strict < keeps the even predecessor on ties
    task automatic model_step(input logic [1:0] sym);
        int wn[4];
        int r0, r1;
        r0 = int'(sym[1]);
        r1 = int'(sym[0]);
        wn = '{default: 1 << 30};
        for (int k = 0; k < 2; k++) begin
            exp_t e;
            int nw[4];
            int mn;
            nw    = '{default: 1 << 30};
            e.dec = '0;
            for (int s = 0; s < 4; s++) begin
                for (int u = 0; u < 2; u++) begin
                    int n, c0, c1, bm, cost;
                    n    = u * 2 + s / 2;
                    c0   = u ^ (s / 2) ^ (s % 2);
                    c1   = u ^ (s % 2);
                    bm   = (c0 ^ r0) + (c1 ^ r1);
                    cost = pm_m[k][s] + bm;
                    if (!NORM && cost > PM_MAX) cost = PM_MAX;
                    if (cost < nw[n]) begin
                        nw[n]    = cost;
                        e.dec[n] = 1'(s % 2);
                    end
                    if (k == 0 && pw[s] + bm < wn[n]) wn[n] = pw[s] + bm;
                end
            end
            if (NORM && nw[0] >= HALF && nw[1] >= HALF && nw[2] >= HALF && nw[3] >= HALF)
                for (int i = 0; i < 4; i++) nw[i] -= HALF;
            mn     = nw[0];
            e.best = 2'd0;
            for (int i = 1; i < 4; i++) if (nw[i] < mn) begin mn = nw[i]; e.best = 2'(i); end
            for (int i = 0; i < 4; i++) pm_m[k][i] = nw[i];
            e.pm = pk(nw[0], nw[1], nw[2], nw[3]);
            e.fe = (sym_cnt == FRAME_LEN - 1);
            if (k == 0) q_a.push_back(e); else q_b.push_back(e);
        end
        for (int i = 0; i < 4; i++) pw[i] = wn[i];
        sym_cnt++;
        if (sym_cnt == FRAME_LEN) begin
            running = 1'b0;
            sym_cnt = 0;
        end
    endtask

    // One clock of stimulus; the model advances exactly where the DUT will sample
    task automatic cycle(input bit st, input bit v, input logic [1:0] sym);
        start     = st;
        in_valid  = v;
        data_recv = sym;
        if (st) begin
            model_init();
            running = 1'b1;
            sym_cnt = 0;
            obs_idx = 0;
        end else if (v && running) begin
            model_step(sym);
        end
        @(posedge clk);
        #1;
        start     = 1'b0;
        in_valid  = 1'b0;
        data_recv = 2'b00;
    endtask

    task automatic run_frame(input int flip);
        logic [1:0] es;
        es = 2'b00;
        cycle(1'b1, 1'b0, 2'b00);
        for (int i = 0; i < FRAME_LEN; i++) begin
            logic [1:0] sym;
            sym = enc(bits[i], es);
            es  = {bits[i], es[1]};
            if (i == flip) sym = sym ^ 2'b11;
            cycle(1'b0, 1'b1, sym);
            if (i % 7 == 3) cycle(1'b0, 1'b0, 2'b00);
        end
        repeat (2) cycle(1'b0, 1'b0, 2'b00);
    endtask

    task automatic score(input int k, input logic [3:0] d, input logic [1:0] b, input logic fe,
                         input logic [4*PM_W-1:0] pm);
        exp_t e;
        checks++;
        if ((k == 0 && q_a.size() == 0) || (k == 1 && q_b.size() == 0)) begin
            errors++;
            $display("FAIL unexpected_out_valid_%0d: got out_valid=1 expected 0", k);
            return;
        end
        if (k == 0) e = q_a.pop_front(); else e = q_b.pop_front();
        if (d !== e.dec || b !== e.best || fe !== e.fe || pm !== e.pm) begin
            errors++;
            $display("FAIL sb_%0d: got dec=%b best=%0d fe=%b pm=%h expected dec=%b best=%0d fe=%b pm=%h",
                     k, d, b, fe, pm, e.dec, e.best, e.fe, e.pm);
        end
        if (k == 0) begin
            if (obs_idx < FRAME_LEN) dec_log[obs_idx] = d;
            obs_idx++;
        end
    endtask

    always @(negedge clk) begin
        if (out_valid_a) score(0, decision_a, best_state_a, frame_end_a, pm_flat_a);
        if (out_valid_b) score(1, decision_b, best_state_b, frame_end_b, pm_flat_b);
        if ((frame_end_a && !out_valid_a) || (frame_end_b && !out_valid_b)) begin
            checks++;
            errors++;
            $display("FAIL frame_end_alone: got frame_end=1 expected 0 without out_valid");
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int mn, nerr;
        logic [1:0] st;
        logic [3:0] dl;

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset state, in_valid ignored while idle
        check("reset_pm_a", pm_flat_a, pk(0, BIAS_A, BIAS_A, BIAS_A));
        check("reset_pm_b", pm_flat_b, pk(0, BIAS_B, BIAS_B, BIAS_B));
        check("reset_out_valid", out_valid_a, 0);
        repeat (3) cycle(1'b0, 1'b1, 2'b00);

        // First symbol 00 after start, hand-computed
        cycle(1'b1, 1'b0, 2'b00);
        cycle(1'b0, 1'b1, 2'b00);
        check("sym00_pm_a", pm_flat_a, pk(0, 9, 2, 9));
        check("sym00_dec_a", decision_a, 4'b0000);
        check("sym00_best_a", best_state_a, 0);
`ifdef ACS_NORM_EN
        check("sym00_pm_b", pm_flat_b, pk(0, 9, 2, 9));
`else
        check("sym00_pm_b_clamp", pm_flat_b, pk(0, 31, 2, 31));
`endif
        repeat (2) cycle(1'b0, 1'b0, 2'b00);

        // Error-free encoded frame with a flushed tail
        for (int i = 0; i < FRAME_LEN; i++) bits[i] = 1'($urandom_range(1, 0));
        bits[FRAME_LEN-2] = 1'b0;
        bits[FRAME_LEN-1] = 1'b0;
        run_frame(-1);
        check("clean_pm0", fld(pm_flat_a, 0), 0);
        check("clean_best", best_state_a, 0);
        repeat (2) cycle(1'b0, 1'b1, 2'b01);
        check("clean_drained", q_a.size(), 0);

        // Same stream with one symbol fully inverted, then trace back
        run_frame(30);
        mn = fld(pm_flat_a, 0);
        for (int i = 1; i < 4; i++) if (fld(pm_flat_a, i) < mn) mn = fld(pm_flat_a, i);
        check("err_min_metric", mn, 2);
        check("err_symbols_seen", obs_idx, FRAME_LEN);
        st   = best_state_a;
        nerr = 0;
        for (int t = FRAME_LEN - 1; t >= 0; t--) begin
            dl = dec_log[t];
            if (st[1] != bits[t]) nerr++;
            st = {st[0], dl[st]};
        end
        check("traceback_bit_errors", nerr, 0);

        // All-11 frame: normalisation / clamping stress
        cycle(1'b1, 1'b0, 2'b00);
        for (int i = 0; i < FRAME_LEN; i++) cycle(1'b0, 1'b1, 2'b11);
        repeat (2) cycle(1'b0, 1'b0, 2'b00);
`ifdef ACS_NORM_EN
        for (int i = 1; i < 4; i++)
            check("norm_diff", fld(pm_flat_a, i) - fld(pm_flat_a, 0), pw[i] - pw[0]);
`endif

        // Restart at symbol 10 (start beats in_valid), async reset at symbol 20
        cycle(1'b1, 1'b0, 2'b00);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, enc(bits[i], 2'b00));
        cycle(1'b1, 1'b1, 2'b11);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 2'(i));
        @(negedge clk);
        #1;
        in_valid  = 1'b1;
        data_recv = 2'b01;
        #1;
        rst_n   = 1'b0;
        running = 1'b0;
        #1;
        check("async_rst_pm_a", pm_flat_a, pk(0, BIAS_A, BIAS_A, BIAS_A));
        check("async_rst_pm_b", pm_flat_b, pk(0, BIAS_B, BIAS_B, BIAS_B));
        check("async_rst_out_valid", out_valid_a, 0);
        check("async_rst_dec", decision_a, 0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("rst_hold_best", best_state_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) cycle(1'b0, 1'b1, 2'b10);
        check("final_drained_a", q_a.size(), 0);
        check("final_drained_b", q_b.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
